// File: rtl/rs_queue_if.sv
// ----------------------------------------------------------------------------
// rs_queue_if
// Bundles the reservation-station handshake and broadcast signals.
//   master : dispatch source / CDB driver / functional unit side (drives
//            flush, dispatch request fields, cdb_valid/cdb_tag, issue_ready)
//   slave  : the reservation station itself (drives in_ready, issue_*,
//            count, full, empty)
// Parameters must match those of the rs_queue instance it connects to.
// ----------------------------------------------------------------------------
interface rs_queue_if #(
   parameter int NUM_ENTRIES = 8,
   parameter int TAG_W       = 6,
   parameter int PAYLOAD_W   = 64,
   parameter int NUM_CDB     = 2
);
   localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

   logic                     flush;
   logic                     in_valid;
   logic                     in_ready;
   logic [TAG_W-1:0]         in_t1_tag;
   logic                     in_t1_rdy;
   logic [TAG_W-1:0]         in_t2_tag;
   logic                     in_t2_rdy;
   logic [TAG_W-1:0]         in_dest_tag;
   logic [PAYLOAD_W-1:0]     in_payload;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic                     issue_valid;
   logic                     issue_ready;
   logic [TAG_W-1:0]         issue_dest_tag;
   logic [PAYLOAD_W-1:0]     issue_payload;
   logic [CNT_W-1:0]         count;
   logic                     full;
   logic                     empty;

   modport master (
      output flush, in_valid, in_t1_tag, in_t1_rdy, in_t2_tag, in_t2_rdy,
             in_dest_tag, in_payload, cdb_valid, cdb_tag, issue_ready,
      input  in_ready, issue_valid, issue_dest_tag, issue_payload,
             count, full, empty
   );

   modport slave (
      input  flush, in_valid, in_t1_tag, in_t1_rdy, in_t2_tag, in_t2_rdy,
             in_dest_tag, in_payload, cdb_valid, cdb_tag, issue_ready,
      output in_ready, issue_valid, issue_dest_tag, issue_payload,
             count, full, empty
   );
endinterface

// File: rtl/rs_queue.sv
// ----------------------------------------------------------------------------
// rs_queue
// Reservation station with CDB wakeup and oldest-first issue selection.
//   clk  : single clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : rs_queue_if.slave
//          flush                 synchronous clear of all entries
//          in_valid/in_ready     dispatch handshake (in_ready = !full)
//          in_t1/t2_tag/_rdy     source operand tags and ready flags
//          in_dest_tag/payload   destination tag and opaque payload
//          cdb_valid/cdb_tag     NUM_CDB broadcast buses, bus k at [k*TAG_W +: TAG_W]
//          issue_valid/ready     issue handshake toward the functional unit
//          issue_dest_tag/payload fields of the selected entry, zero when idle
//          count/full/empty      occupancy
// ----------------------------------------------------------------------------
module rs_queue #(
   parameter int NUM_ENTRIES = 8,
   parameter int TAG_W       = 6,
   parameter int PAYLOAD_W   = 64,
   parameter int NUM_CDB     = 2
) (
   input  logic      clk,
   input  logic      rst,
   rs_queue_if.slave bus
);
   localparam int                CNT_W    = $clog2(NUM_ENTRIES + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_ENTRIES);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_ENTRIES-1:0] ENT_ONE = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};

   // Per-entry state
   logic [NUM_ENTRIES-1:0] busy_q,   busy_d;
   logic [NUM_ENTRIES-1:0] t1_rdy_q, t1_rdy_d;
   logic [NUM_ENTRIES-1:0] t2_rdy_q, t2_rdy_d;
   logic [TAG_W-1:0]       t1_tag_q   [NUM_ENTRIES];
   logic [TAG_W-1:0]       t1_tag_d   [NUM_ENTRIES];
   logic [TAG_W-1:0]       t2_tag_q   [NUM_ENTRIES];
   logic [TAG_W-1:0]       t2_tag_d   [NUM_ENTRIES];
   logic [TAG_W-1:0]       dest_tag_q [NUM_ENTRIES];
   logic [TAG_W-1:0]       dest_tag_d [NUM_ENTRIES];
   logic [PAYLOAD_W-1:0]   payload_q  [NUM_ENTRIES];
   logic [PAYLOAD_W-1:0]   payload_d  [NUM_ENTRIES];
   // age_q[i][j] = 1 means entry j is older than entry i
   logic [NUM_ENTRIES-1:0] age_q      [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] age_d      [NUM_ENTRIES];
   logic [CNT_W-1:0]       count_q, count_d;

   // Combinational control
   logic                   full_s;
   logic                   disp_fire_s;
   logic                   issue_fire_s;
   logic                   issue_valid_s;
   logic [NUM_ENTRIES-1:0] free_s;
   logic [NUM_ENTRIES-1:0] disp_slot_s;
   logic [NUM_ENTRIES-1:0] disp_mask_s;
   logic [NUM_ENTRIES-1:0] eligible_s;
   logic [NUM_ENTRIES-1:0] sel_s;
   logic [NUM_ENTRIES-1:0] iss_mask_s;
   logic                   in_t1_hit_s;
   logic                   in_t2_hit_s;
   logic [TAG_W-1:0]       issue_dest_s;
   logic [PAYLOAD_W-1:0]   issue_payload_s;

   // True when any valid broadcast bus carries the given tag; duplicates
   // across buses collapse into a single hit.
   function automatic logic cdb_match(
      input logic [TAG_W-1:0]         tag,
      input logic [NUM_CDB-1:0]       vld,
      input logic [NUM_CDB*TAG_W-1:0] tags
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         hit = hit | (vld[k] & (tags[k*TAG_W +: TAG_W] == tag));
      end
      return hit;
   endfunction

   // Dispatch slot choice, issue selection and handshake qualifiers
   always_comb begin
      full_s       = (count_q == FULL_CNT);
      disp_fire_s  = bus.in_valid & ~full_s;
      free_s       = ~busy_q;
      // Isolate the lowest set bit of free_s: x & (-x)
      disp_slot_s  = free_s & (~free_s + ENT_ONE);
      disp_mask_s  = disp_slot_s & {NUM_ENTRIES{disp_fire_s}};
      eligible_s   = busy_q & t1_rdy_q & t2_rdy_q;
      // Oldest eligible entry: no other eligible entry is older than it
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         sel_s[i] = eligible_s[i] & ((age_q[i] & eligible_s) == {NUM_ENTRIES{1'b0}});
      end
      issue_valid_s = |sel_s;
      issue_fire_s  = issue_valid_s & bus.issue_ready;
      iss_mask_s    = sel_s & {NUM_ENTRIES{issue_fire_s}};
      in_t1_hit_s   = cdb_match(bus.in_t1_tag, bus.cdb_valid, bus.cdb_tag);
      in_t2_hit_s   = cdb_match(bus.in_t2_tag, bus.cdb_valid, bus.cdb_tag);
   end

   // Issue data mux; sel_s is one-hot or zero so an AND-OR tree suffices
   always_comb begin
      issue_dest_s    = {TAG_W{1'b0}};
      issue_payload_s = {PAYLOAD_W{1'b0}};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         issue_dest_s    = issue_dest_s    | (dest_tag_q[i] & {TAG_W{sel_s[i]}});
         issue_payload_s = issue_payload_s | (payload_q[i]  & {PAYLOAD_W{sel_s[i]}});
      end
   end

   // Next-state: flush, wakeup, issue retirement, dispatch and occupancy
   always_comb begin
      busy_d   = busy_q;
      t1_rdy_d = t1_rdy_q;
      t2_rdy_d = t2_rdy_q;
      count_d  = count_q;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         t1_tag_d[i]   = t1_tag_q[i];
         t2_tag_d[i]   = t2_tag_q[i];
         dest_tag_d[i] = dest_tag_q[i];
         payload_d[i]  = payload_q[i];
         age_d[i]      = age_q[i];
      end

      if (bus.flush) begin
         busy_d   = {NUM_ENTRIES{1'b0}};
         t1_rdy_d = {NUM_ENTRIES{1'b0}};
         t2_rdy_d = {NUM_ENTRIES{1'b0}};
         count_d  = {CNT_W{1'b0}};
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_d[i] = {NUM_ENTRIES{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (busy_q[i] && cdb_match(t1_tag_q[i], bus.cdb_valid, bus.cdb_tag)) begin
               t1_rdy_d[i] = 1'b1;
            end else begin
               t1_rdy_d[i] = t1_rdy_q[i];
            end
            if (busy_q[i] && cdb_match(t2_tag_q[i], bus.cdb_valid, bus.cdb_tag)) begin
               t2_rdy_d[i] = 1'b1;
            end else begin
               t2_rdy_d[i] = t2_rdy_q[i];
            end

            if (iss_mask_s[i]) begin
               busy_d[i] = 1'b0;
            end else begin
               busy_d[i] = busy_q[i];
            end

            if (disp_mask_s[i]) begin
               busy_d[i]     = 1'b1;
               t1_tag_d[i]   = bus.in_t1_tag;
               t2_tag_d[i]   = bus.in_t2_tag;
               t1_rdy_d[i]   = bus.in_t1_rdy | in_t1_hit_s;
               t2_rdy_d[i]   = bus.in_t2_rdy | in_t2_hit_s;
               dest_tag_d[i] = bus.in_dest_tag;
               payload_d[i]  = bus.in_payload;
               // Every entry that stays busy is older than the newcomer
               age_d[i]      = busy_q & ~iss_mask_s;
            end else begin
               // The newcomer's column is cleared so nobody sees it as older
               age_d[i]      = age_q[i] & ~disp_mask_s;
            end
         end

         case ({disp_fire_s, issue_fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= {NUM_ENTRIES{1'b0}};
         t1_rdy_q <= {NUM_ENTRIES{1'b0}};
         t2_rdy_q <= {NUM_ENTRIES{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            t1_tag_q[i]   <= {TAG_W{1'b0}};
            t2_tag_q[i]   <= {TAG_W{1'b0}};
            dest_tag_q[i] <= {TAG_W{1'b0}};
            payload_q[i]  <= {PAYLOAD_W{1'b0}};
            age_q[i]      <= {NUM_ENTRIES{1'b0}};
         end
      end else begin
         busy_q   <= busy_d;
         t1_rdy_q <= t1_rdy_d;
         t2_rdy_q <= t2_rdy_d;
         count_q  <= count_d;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            t1_tag_q[i]   <= t1_tag_d[i];
            t2_tag_q[i]   <= t2_tag_d[i];
            dest_tag_q[i] <= dest_tag_d[i];
            payload_q[i]  <= payload_d[i];
            age_q[i]      <= age_d[i];
         end
      end
   end

   assign bus.in_ready       = ~full_s;
   assign bus.full           = full_s;
   assign bus.empty          = (count_q == {CNT_W{1'b0}});
   assign bus.count          = count_q;
   assign bus.issue_valid    = issue_valid_s;
   assign bus.issue_dest_tag = issue_dest_s;
   assign bus.issue_payload  = issue_payload_s;

endmodule

// File: tb/tb_rs_queue.sv
// ----------------------------------------------------------------------------
// tb_rs_queue
// Directed, table-driven bench for rs_queue with hand-computed expectations,
// followed by hand-written sequences for fill/drain, flush and async reset.
// ----------------------------------------------------------------------------
module tb_rs_queue;
   localparam int NE = 8;
   localparam int TW = 6;
   localparam int PW = 64;
   localparam int NC = 2;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   rs_queue_if #(.NUM_ENTRIES(NE), .TAG_W(TW), .PAYLOAD_W(PW), .NUM_CDB(NC)) bus ();

   rs_queue #(.NUM_ENTRIES(NE), .TAG_W(TW), .PAYLOAD_W(PW), .NUM_CDB(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid;
      logic [5:0]  t1_tag;
      logic        t1_rdy;
      logic [5:0]  t2_tag;
      logic        t2_rdy;
      logic [5:0]  dest;
      logic [63:0] payload;
      logic [1:0]  cdb_valid;
      logic [11:0] cdb_tag;
      logic        issue_ready;
      logic        exp_iv;
      logic [5:0]  exp_dest;
      logic [63:0] exp_pl;
      logic [3:0]  exp_cnt;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_state(input string pfx, input logic iv, input logic [5:0] dest,
                            input logic [63:0] pl, input logic [3:0] cnt);
      chk({pfx, " issue_valid"},    64'(bus.issue_valid),    64'(iv));
      chk({pfx, " issue_dest_tag"}, 64'(bus.issue_dest_tag), 64'(dest));
      chk({pfx, " issue_payload"},  bus.issue_payload,       pl);
      chk({pfx, " count"},          64'(bus.count),          64'(cnt));
      chk({pfx, " empty"},          64'(bus.empty),          64'(cnt == 4'd0));
      chk({pfx, " full"},           64'(bus.full),           64'(cnt == 4'd8));
      chk({pfx, " in_ready"},       64'(bus.in_ready),       64'(cnt != 4'd8));
   endtask

   task automatic idle();
      bus.flush       = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_t1_tag   = 6'd0;
      bus.in_t1_rdy   = 1'b0;
      bus.in_t2_tag   = 6'd0;
      bus.in_t2_rdy   = 1'b0;
      bus.in_dest_tag = 6'd0;
      bus.in_payload  = 64'd0;
      bus.cdb_valid   = 2'b00;
      bus.cdb_tag     = 12'd0;
      bus.issue_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_disp(input logic [5:0] t1, input logic r1, input logic [5:0] t2,
                           input logic r2, input logic [5:0] dest, input logic [63:0] pl);
      bus.in_valid    = 1'b1;
      bus.in_t1_tag   = t1;
      bus.in_t1_rdy   = r1;
      bus.in_t2_tag   = t2;
      bus.in_t2_rdy   = r2;
      bus.in_dest_tag = dest;
      bus.in_payload  = pl;
   endtask

   task automatic apply(input vec_t v);
      bus.in_valid    = v.in_valid;
      bus.in_t1_tag   = v.t1_tag;
      bus.in_t1_rdy   = v.t1_rdy;
      bus.in_t2_tag   = v.t2_tag;
      bus.in_t2_rdy   = v.t2_rdy;
      bus.in_dest_tag = v.dest;
      bus.in_payload  = v.payload;
      bus.cdb_valid   = v.cdb_valid;
      bus.cdb_tag     = v.cdb_tag;
      bus.issue_ready = v.issue_ready;
   endtask

   // Watchdog: the bench uses fixed cycle counts, this only guards a stall
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   logic [5:0]  exp_dest;
   logic [63:0] exp_pl;

   initial begin
      tests = 0;
      fails = 0;
      idle();
      rst = 1'b1;
      #2;
      chk_state("reset", 1'b0, 6'd0, 64'd0, 4'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fields: in_valid,t1,t1r,t2,t2r,dest,payload,cdb_valid,cdb_tag,issue_ready | iv,dest,pl,count
      // cdb_tag packs bus1 in [11:6], bus0 in [5:0]
      vecs[0]  = '{1'b1, 6'd1, 1'b0, 6'd2, 1'b0, 6'd10, 64'hA, 2'b00, 12'h000, 1'b0, 1'b0, 6'd0,  64'h0, 4'd1};
      vecs[1]  = '{1'b1, 6'd3, 1'b0, 6'd4, 1'b0, 6'd11, 64'hB, 2'b00, 12'h000, 1'b0, 1'b0, 6'd0,  64'h0, 4'd2};
      vecs[2]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b01, 12'h003, 1'b0, 1'b0, 6'd0,  64'h0, 4'd2};
      vecs[3]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b10, 12'h100, 1'b0, 1'b1, 6'd11, 64'hB, 4'd2};
      // Tag 1 on both buses at once; B stays selected while A still waits on tag 2
      vecs[4]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b11, 12'h041, 1'b0, 1'b1, 6'd11, 64'hB, 4'd2};
      // A becomes eligible and, being older, takes over selection
      vecs[5]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b01, 12'h002, 1'b0, 1'b1, 6'd10, 64'hA, 4'd2};
      vecs[6]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b00, 12'h000, 1'b1, 1'b1, 6'd11, 64'hB, 4'd1};
      // Issue B while dispatching C whose t1 is bypassed from bus 1
      vecs[7]  = '{1'b1, 6'd5, 1'b0, 6'd9, 1'b1, 6'd12, 64'hC, 2'b10, 12'h140, 1'b1, 1'b1, 6'd12, 64'hC, 4'd1};
      vecs[8]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b00, 12'h000, 1'b1, 1'b0, 6'd0,  64'h0, 4'd0};
      // Matching tag present but bus not valid: no bypass
      vecs[9]  = '{1'b1, 6'd7, 1'b0, 6'd0, 1'b1, 6'd13, 64'hD, 2'b00, 12'h007, 1'b0, 1'b0, 6'd0,  64'h0, 4'd1};
      vecs[10] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b01, 12'h008, 1'b0, 1'b0, 6'd0,  64'h0, 4'd1};
      vecs[11] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b10, 12'h1C0, 1'b0, 1'b1, 6'd13, 64'hD, 4'd1};
      vecs[12] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0,  64'h0, 2'b00, 12'h000, 1'b1, 1'b0, 6'd0,  64'h0, 4'd0};

      for (int i = 0; i < 13; i++) begin
         apply(vecs[i]);
         tick();
         chk_state($sformatf("vec%0d", i), vecs[i].exp_iv, vecs[i].exp_dest,
                   vecs[i].exp_pl, vecs[i].exp_cnt);
      end

      // Fill eight ready entries with the functional unit stalled
      for (int i = 0; i < 8; i++) begin
         set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'(20 + i), 64'(100 + i));
         tick();
      end
      chk_state("fill", 1'b1, 6'd20, 64'd100, 4'd8);

      // Dispatch while full is ignored
      set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'd63, 64'd999);
      tick();
      chk_state("full_ignore", 1'b1, 6'd20, 64'd100, 4'd8);

      // Dispatch and issue together while full: only the issue happens
      set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'd40, 64'd140);
      bus.issue_ready = 1'b1;
      tick();
      chk_state("full_disp_issue", 1'b1, 6'd21, 64'd101, 4'd7);

      // Freed slot accepts the retry; it is the youngest entry
      set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'd40, 64'd140);
      tick();
      chk_state("refill", 1'b1, 6'd21, 64'd101, 4'd8);

      // Drain in dispatch order, one per cycle
      for (int i = 0; i < 8; i++) begin
         exp_dest = (i < 7) ? 6'(21 + i) : 6'd40;
         exp_pl   = (i < 7) ? 64'(101 + i) : 64'd140;
         chk_state($sformatf("drain%0d", i), 1'b1, exp_dest, exp_pl, 4'(8 - i));
         bus.issue_ready = 1'b1;
         tick();
      end
      chk_state("drained", 1'b0, 6'd0, 64'd0, 4'd0);

      // Flush beats same-cycle dispatch, wakeup and issue
      for (int i = 0; i < 3; i++) begin
         set_disp(6'(30 + i), 1'b0, 6'd33, 1'b1, 6'(50 + i), 64'(50 + i));
         tick();
      end
      chk_state("pre_flush", 1'b0, 6'd0, 64'd0, 4'd3);
      set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'd60, 64'd60);
      bus.flush       = 1'b1;
      bus.cdb_valid   = 2'b01;
      bus.cdb_tag     = 12'd30;
      bus.issue_ready = 1'b1;
      tick();
      chk_state("flush", 1'b0, 6'd0, 64'd0, 4'd0);
      tick();
      chk_state("flush_hold", 1'b0, 6'd0, 64'd0, 4'd0);

      // Asynchronous reset between edges with four entries busy
      for (int i = 0; i < 4; i++) begin
         set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'(8 + i), 64'(200 + i));
         tick();
      end
      chk_state("pre_reset", 1'b1, 6'd8, 64'd200, 4'd4);
      #3;
      rst = 1'b1;
      #1;
      chk_state("async_reset", 1'b0, 6'd0, 64'd0, 4'd0);
      #1;
      rst = 1'b0;
      set_disp(6'd0, 1'b1, 6'd0, 1'b1, 6'd44, 64'd444);
      tick();
      chk_state("post_reset", 1'b1, 6'd44, 64'd444, 4'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rs_queue.md
RS_QUEUE -- requirements
Module: rs_queue

Interface
REQ-001 SHALL expose parameter NUM_ENTRIES, default 8, number of station entries (range 2..32).
REQ-002 SHALL expose parameter TAG_W, default 6, physical tag width.
REQ-003 SHALL expose parameter PAYLOAD_W, default 64, opaque instruction payload width.
REQ-004 SHALL expose parameter NUM_CDB, default 2, number of broadcast buses.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-007 flush  in  1  synchronous clear of all entries.
REQ-008 in_valid  in  1  dispatch request.
REQ-009 in_ready  out  1  high when at least one entry is free.
REQ-010 in_t1_tag, in_t2_tag  in  TAG_W each  source operand tags.
REQ-011 in_t1_rdy, in_t2_rdy  in  1 each  operand already available at dispatch.
REQ-012 in_dest_tag  in  TAG_W  destination tag; in_payload  in  PAYLOAD_W  opaque payload.
REQ-013 cdb_valid  in  NUM_CDB  per-bus broadcast valid; cdb_tag  in  NUM_CDB*TAG_W  bus k occupies bits [k*TAG_W +: TAG_W].
REQ-014 issue_valid  out  1  an entry is selected for issue; issue_ready  in  1  functional unit accepts.
REQ-015 issue_dest_tag  out  TAG_W; issue_payload  out  PAYLOAD_W  fields of the selected entry.
REQ-016 count  out  $clog2(NUM_ENTRIES+1)  occupied entries; full, empty  out  1 each.

Function
REQ-017 Each entry SHALL hold: busy, t1_tag, t1_rdy, t2_tag, t2_rdy, dest_tag, payload, plus an NUM_ENTRIES x NUM_ENTRIES age matrix row.
REQ-018 Dispatch SHALL fire when in_valid && in_ready; the new entry goes into the lowest-index free slot.
REQ-019 in_ready SHALL equal !full of the current cycle; no dispatch when full, even if an issue fires that cycle; in_valid while full is ignored with no state change.
REQ-020 Wakeup: any busy entry operand with rdy=0 whose tag equals cdb_tag[k] with cdb_valid[k]=1 for any k SHALL set rdy=1 at the next edge.
REQ-021 Dispatch bypass: an incoming operand whose tag matches a valid CDB bus in the dispatch cycle SHALL be stored with rdy=1.
REQ-022 An entry is eligible when busy && t1_rdy && t2_rdy (registered values); earliest issue is the cycle after the waking broadcast (one-cycle wakeup-to-issue latency).
REQ-023 Selection SHALL pick the oldest eligible entry per the age matrix; the age matrix marks a newly dispatched entry as younger than all busy entries.
REQ-024 issue_valid, issue_dest_tag and issue_payload SHALL be combinational from registered state; payload/tag are zero when issue_valid=0.
REQ-025 Issue fires when issue_valid && issue_ready; the selected entry's busy clears at the next edge; if issue_ready=0 the same entry stays selected unless an older entry becomes eligible.
REQ-026 Simultaneous dispatch and issue in one cycle SHALL both take effect; count is unchanged.
REQ-027 count SHALL equal the number of busy entries; full = (count==NUM_ENTRIES); empty = (count==0).
REQ-028 Duplicate matching tags on multiple CDB buses in one cycle SHALL behave as a single match.
REQ-029 flush SHALL clear all busy bits at the next edge and take priority over a same-cycle dispatch, issue or wakeup.

Reset
REQ-030 On reset assertion, independent of clock: all busy=0, all rdy=0, age matrix zero, count=0, empty=1, full=0, in_ready=1, issue_valid=0, issue_dest_tag=0, issue_payload=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first dispatch after deassertion lands in slot 0.

Verification
REQ-032 Dispatch A (t1=1,t2=2 not ready) then B (t1=3,t2=4 not ready); cdb tag 3 then tag 4 -> issue_valid high the cycle after tag 4 with B's dest_tag; A stays until tags 1,2 broadcast.
REQ-033 Fill 8 entries all ready, issue_ready=0 -> full=1, in_ready=0, further in_valid ignored; raise issue_ready -> entries issue in dispatch order, one per cycle, count 8..0.
REQ-034 Dispatch with t1_tag=5 while cdb_valid[1]=1, cdb_tag[1]=5, t2_rdy=1 -> entry eligible next cycle, issue_valid=1.
REQ-035 Full station with oldest entry ready: dispatch + issue same cycle -> dispatch rejected, count 8 to 7; next cycle dispatch accepted into freed slot, count 8.
REQ-036 Three entries busy, flush asserted together with in_valid -> count=0, empty=1 next cycle, no new entry stored.
REQ-037 Reset asserted between edges with 4 entries busy -> outputs take reset values immediately, before the next rising edge.
